// File: rtl/fm_wb_collector.sv
// ---------------------------------------------------------------------------
// fm_wb_collector
//   Gathers per-row write-back traffic from a PE array and serialises it onto
//   two memory write ports: one for feature-map bytes and one for 6-bit guard
//   words. Each row owns a small data FIFO, a single-entry guard register, a
//   finish flag and two address counters. Two independent round-robin
//   arbiters pick one data FIFO and one guard register per cycle.
//
//   Sequencing: IDLE -(start_i)-> RUN -(all rows finished)-> DRAIN
//               -(all buffers empty)-> DONE -(1 cycle)-> IDLE
//
//   Ports
//     clk, rst_n               clock, async active-low reset
//     start_i                  start pulse, loads base addresses (IDLE only)
//     base_addr_i/guard_base_i per-row base addresses
//     write_back_data_i(+valid)/fm_buf_ready   per-row data stream
//     guard_i(+valid)/guard_buf_ready          per-row guard stream
//     write_back_finish        per-row last-word pulse
//     fm_we_o/fm_addr_o/fm_wdata_o             feature-map write port (registered)
//     guard_we_o/guard_addr_o/guard_wdata_o    guard write port (registered)
//     done_o                   one-cycle completion pulse
//
//   Build option
//     FM_WB_ZERO_SKIP_EN : when defined, granted data bytes equal to 0x00 are
//                          not written, but the row address still advances.
// ---------------------------------------------------------------------------

package diff_demo_pkg;
    parameter int CONF_PE_ROW = 2;
endpackage

// ---------------------------------------------------------------------------
// fm_wb_row : per-row storage.
//   Data FIFO (FIFO_DEPTH x 8), one-entry guard register, finish flag and the
//   data/guard address counters. Counters advance on every pop.
// ---------------------------------------------------------------------------
module fm_wb_row #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              active,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] guard_base,
    input  logic [7:0]        data,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [5:0]        guard,
    input  logic              guard_valid,
    output logic              guard_ready,
    input  logic              finish,
    input  logic              data_pop,
    input  logic              guard_pop,
    output logic              data_avail,
    output logic [7:0]        data_head,
    output logic              guard_avail,
    output logic [5:0]        guard_word,
    output logic              finish_flag,
    output logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] guard_addr
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [FIFO_DEPTH-1:0][7:0] mem;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic                       push;
    logic                       guard_push;
    logic                       guard_full;

    assign data_ready  = active && (count != CW'(FIFO_DEPTH));
    assign push        = data_valid && data_ready;
    assign data_avail  = (count != '0);
    assign data_head   = mem[rd_ptr];

    // Guard register accepts only when empty, so push and pop never coincide.
    assign guard_ready = active && !guard_full;
    assign guard_push  = guard_valid && guard_ready;
    assign guard_avail = guard_full;

    // Data FIFO; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (data_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, data_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_full <= 1'b0;
            guard_word <= '0;
        end else if (guard_push) begin
            guard_full <= 1'b1;
            guard_word <= guard;
        end else if (guard_pop) begin
            guard_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_flag <= 1'b0;
            data_addr   <= '0;
            guard_addr  <= '0;
        end else if (load) begin
            finish_flag <= 1'b0;
            data_addr   <= base_addr;
            guard_addr  <= guard_base;
        end else begin
            if (active && finish) finish_flag <= 1'b1;
            if (data_pop)         data_addr   <= data_addr + 1'b1;
            if (guard_pop)        guard_addr  <= guard_addr + 1'b1;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// fm_wb_rr_arb : round-robin arbiter. Search starts at ptr; after a grant to
// row r the pointer moves to r+1 (mod N).
// ---------------------------------------------------------------------------
module fm_wb_rr_arb #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_idx,
    output logic [N-1:0]  gnt_oh
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (en && !gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module fm_wb_collector #(
    parameter int CONF_PE_ROW = diff_demo_pkg::CONF_PE_ROW,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [CONF_PE_ROW-1:0][ADDR_W-1:0] base_addr_i,
    input  logic [CONF_PE_ROW-1:0][ADDR_W-1:0] guard_base_i,
    input  logic [CONF_PE_ROW-1:0][7:0]        write_back_data_i,
    input  logic [CONF_PE_ROW-1:0]             write_back_data_i_valid,
    output logic [CONF_PE_ROW-1:0]             fm_buf_ready,
    input  logic [CONF_PE_ROW-1:0][5:0]        guard_i,
    input  logic [CONF_PE_ROW-1:0]             guard_i_valid,
    output logic [CONF_PE_ROW-1:0]             guard_buf_ready,
    input  logic [CONF_PE_ROW-1:0]             write_back_finish,
    output logic                              fm_we_o,
    output logic [ADDR_W-1:0]                 fm_addr_o,
    output logic [7:0]                        fm_wdata_o,
    output logic                              guard_we_o,
    output logic [ADDR_W-1:0]                 guard_addr_o,
    output logic [5:0]                        guard_wdata_o,
    output logic                              done_o
);
    localparam int IW = (CONF_PE_ROW > 1) ? $clog2(CONF_PE_ROW) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       active;
    logic       load;

    logic [CONF_PE_ROW-1:0]             data_avail;
    logic [CONF_PE_ROW-1:0]             guard_avail;
    logic [CONF_PE_ROW-1:0]             finish_flag;
    logic [CONF_PE_ROW-1:0]             data_pop;
    logic [CONF_PE_ROW-1:0]             guard_pop;
    logic [CONF_PE_ROW-1:0][7:0]        data_head;
    logic [CONF_PE_ROW-1:0][5:0]        guard_word;
    logic [CONF_PE_ROW-1:0][ADDR_W-1:0] data_addr;
    logic [CONF_PE_ROW-1:0][ADDR_W-1:0] guard_addr;

    logic          fm_gnt_vld;
    logic [IW-1:0] fm_gnt;
    logic          gd_gnt_vld;
    logic [IW-1:0] gd_gnt;
    logic          fm_keep;

    assign active = (state == S_RUN) || (state == S_DRAIN);
    assign load   = start_i && (state == S_IDLE);
    assign done_o = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load) state_nxt = S_RUN;
            S_RUN:   if (&finish_flag) state_nxt = S_DRAIN;
            S_DRAIN: if (!(|data_avail) && !(|guard_avail)) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    for (genvar r = 0; r < CONF_PE_ROW; r++) begin : g_row
        fm_wb_row #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .ADDR_W     (ADDR_W)
        ) u_row (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (load),
            .active      (active),
            .base_addr   (base_addr_i[r]),
            .guard_base  (guard_base_i[r]),
            .data        (write_back_data_i[r]),
            .data_valid  (write_back_data_i_valid[r]),
            .data_ready  (fm_buf_ready[r]),
            .guard       (guard_i[r]),
            .guard_valid (guard_i_valid[r]),
            .guard_ready (guard_buf_ready[r]),
            .finish      (write_back_finish[r]),
            .data_pop    (data_pop[r]),
            .guard_pop   (guard_pop[r]),
            .data_avail  (data_avail[r]),
            .data_head   (data_head[r]),
            .guard_avail (guard_avail[r]),
            .guard_word  (guard_word[r]),
            .finish_flag (finish_flag[r]),
            .data_addr   (data_addr[r]),
            .guard_addr  (guard_addr[r])
        );
    end

    // Arbiters only run in RUN/DRAIN, which keeps both write enables low in
    // IDLE and DONE: DRAIN leaves only once nothing is left to grant.
    fm_wb_rr_arb #(.N(CONF_PE_ROW), .IW(IW)) u_fm_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (active),
        .req     (data_avail),
        .gnt_vld (fm_gnt_vld),
        .gnt_idx (fm_gnt),
        .gnt_oh  (data_pop)
    );

    fm_wb_rr_arb #(.N(CONF_PE_ROW), .IW(IW)) u_gd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (active),
        .req     (guard_avail),
        .gnt_vld (gd_gnt_vld),
        .gnt_idx (gd_gnt),
        .gnt_oh  (guard_pop)
    );

`ifdef FM_WB_ZERO_SKIP_EN
    // Zero bytes are popped and consume an address but produce no write.
    assign fm_keep = (data_head[fm_gnt] != 8'h00);
`else
    assign fm_keep = 1'b1;
`endif

    // Registered memory ports: a grant in cycle N appears on the port in N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_we_o    <= 1'b0;
            fm_addr_o  <= '0;
            fm_wdata_o <= '0;
        end else begin
            fm_we_o <= fm_gnt_vld && fm_keep;
            if (fm_gnt_vld) begin
                fm_addr_o  <= data_addr[fm_gnt];
                fm_wdata_o <= data_head[fm_gnt];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_we_o    <= 1'b0;
            guard_addr_o  <= '0;
            guard_wdata_o <= '0;
        end else begin
            guard_we_o <= gd_gnt_vld;
            if (gd_gnt_vld) begin
                guard_addr_o  <= guard_addr[gd_gnt];
                guard_wdata_o <= guard_word[gd_gnt];
            end
        end
    end
endmodule

// File: tb/tb_fm_wb_collector.sv
// Self-checking bench for fm_wb_collector (2 rows, depth 4, 12-bit addresses).
// Memory writes are logged by a negedge monitor; each scenario compares the
// log and sampled handshakes against expectations built from the rules.
module tb_fm_wb_collector;
    localparam int N     = 2;
    localparam int AW    = 12;
    localparam int DEPTH = 4;
`ifdef FM_WB_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_i;
    logic [N-1:0][AW-1:0]  base_addr_i;
    logic [N-1:0][AW-1:0]  guard_base_i;
    logic [N-1:0][7:0]     wb_data;
    logic [N-1:0]          wb_valid;
    logic [N-1:0]          fm_buf_ready;
    logic [N-1:0][5:0]     guard_i;
    logic [N-1:0]          guard_valid;
    logic [N-1:0]          guard_buf_ready;
    logic [N-1:0]          wb_finish;
    logic                  fm_we_o;
    logic [AW-1:0]         fm_addr_o;
    logic [7:0]            fm_wdata_o;
    logic                  guard_we_o;
    logic [AW-1:0]         guard_addr_o;
    logic [5:0]            guard_wdata_o;
    logic                  done_o;

    int errors = 0;
    int checks = 0;

    logic [19:0] fm_log[$];
    logic [17:0] gd_log[$];

    always #5 clk = ~clk;

    fm_wb_collector #(.CONF_PE_ROW(N), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start_i                 (start_i),
        .base_addr_i             (base_addr_i),
        .guard_base_i            (guard_base_i),
        .write_back_data_i       (wb_data),
        .write_back_data_i_valid (wb_valid),
        .fm_buf_ready            (fm_buf_ready),
        .guard_i                 (guard_i),
        .guard_i_valid           (guard_valid),
        .guard_buf_ready         (guard_buf_ready),
        .write_back_finish       (wb_finish),
        .fm_we_o                 (fm_we_o),
        .fm_addr_o               (fm_addr_o),
        .fm_wdata_o              (fm_wdata_o),
        .guard_we_o              (guard_we_o),
        .guard_addr_o            (guard_addr_o),
        .guard_wdata_o           (guard_wdata_o),
        .done_o                  (done_o)
    );

    always @(negedge clk) begin
        if (fm_we_o)    fm_log.push_back({fm_addr_o, fm_wdata_o});
        if (guard_we_o) gd_log.push_back({guard_addr_o, guard_wdata_o});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_i      = 1'b0;
        base_addr_i  = '0;
        guard_base_i = '0;
        wb_data      = '0;
        wb_valid     = '0;
        guard_i      = '0;
        guard_valid  = '0;
        wb_finish    = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fm_log.delete();
        gd_log.delete();
    endtask

    task automatic do_start(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                            input logic [AW-1:0] g0, input logic [AW-1:0] g1);
        base_addr_i[0]  = b0;
        base_addr_i[1]  = b1;
        guard_base_i[0] = g0;
        guard_base_i[1] = g1;
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        clear_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({fm_we_o, guard_we_o, done_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 000", {fm_we_o, guard_we_o, done_o});
        end
        checks++;
        if ({fm_addr_o, fm_wdata_o, guard_addr_o, guard_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_ports: got fm %h/%h guard %h/%h required all 0",
                     fm_addr_o, fm_wdata_o, guard_addr_o, guard_wdata_o);
        end
        checks++;
        if ({fm_buf_ready, guard_buf_ready} !== '0) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b required 00/00", fm_buf_ready, guard_buf_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Traffic offered without start must be refused in IDLE.
        wb_valid    = '1;
        guard_valid = '1;
        wb_data     = 16'h5A5A;
        wb_finish   = '1;
        n = fm_log.size();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({fm_buf_ready, guard_buf_ready} !== '0) begin
                errors++;
                $display("FAIL idle_ready: got %b/%b required 00/00", fm_buf_ready, guard_buf_ready);
            end
            cycle();
        end
        @(negedge clk);
        checks++;
        if (fm_log.size() !== n || gd_log.size() !== 0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_writes: got fm=%0d guard=%0d done=%b required %0d/0/0",
                     fm_log.size(), gd_log.size(), done_o, n);
        end
        clear_inputs();
    endtask

    task automatic test_basic();
        bit seen;
        bit got;
        apply_reset();
        do_start(12'h010, 12'h100, 12'h200, 12'h300);
        wb_data[0]  = 8'hA1;
        wb_valid[0] = 1'b1;
        guard_i[0]  = 6'h2A;
        guard_i[1]  = 6'h15;
        guard_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (fm_buf_ready !== 2'b11 || guard_buf_ready !== 2'b11) begin
            errors++;
            $display("FAIL run_ready: got %b/%b required 11/11", fm_buf_ready, guard_buf_ready);
        end
        cycle();
        wb_valid       = '0;
        guard_valid    = '0;
        start_i        = 1'b1;          // must be ignored in RUN
        base_addr_i[0] = 12'h0F0;
        @(negedge clk);
        checks++;
        if (guard_buf_ready !== 2'b00) begin
            errors++;
            $display("FAIL guard_hold_ready: got %b required 00", guard_buf_ready);
        end
        cycle();
        start_i      = 1'b0;
        wb_data[0]   = 8'hA2;
        wb_valid[0]  = 1'b1;
        wb_finish[0] = 1'b1;
        cycle();
        wb_valid  = '0;
        wb_finish = '0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
            cycle();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL early_done: got done=1 required 0 before row1 finishes");
        end
        checks++;
        if (fm_log.size() !== 2) begin
            errors++;
            $display("FAIL basic_fm_count: got %0d required 2", fm_log.size());
        end else begin
            checks++;
            if (fm_log[0] !== {12'h010, 8'hA1} || fm_log[1] !== {12'h011, 8'hA2}) begin
                errors++;
                $display("FAIL basic_fm_writes: got %h,%h required 010a1,011a2", fm_log[0], fm_log[1]);
            end
        end
        checks++;
        if (gd_log.size() !== 2) begin
            errors++;
            $display("FAIL basic_guard_count: got %0d required 2", gd_log.size());
        end else begin
            checks++;
            if (gd_log[0] !== {12'h200, 6'h2A} || gd_log[1] !== {12'h300, 6'h15}) begin
                errors++;
                $display("FAIL basic_guard_writes: got %h,%h required %h,%h",
                         gd_log[0], gd_log[1], {12'h200, 6'h2A}, {12'h300, 6'h15});
            end
        end
        wb_finish[1] = 1'b1;
        cycle();
        wb_finish = '0;
        wait_done(20, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL basic_done: got no done within 20 cycles required pulse");
        end else begin
            checks++;
            if (fm_we_o !== 1'b0 || guard_we_o !== 1'b0) begin
                errors++;
                $display("FAIL done_we: got %b/%b required 0/0", fm_we_o, guard_we_o);
            end
            cycle();
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0 || fm_buf_ready !== 2'b00) begin
                errors++;
                $display("FAIL done_width: got done=%b ready=%b required 0/00", done_o, fm_buf_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          acc[2];
        int          wcnt[2];
        int          occ;
        bit          exp_rdy;
        bit          saw_full[2];
        bit          got;
        int          r;
        logic [AW-1:0] nxt[2];
        logic [19:0] q0[$];
        logic [19:0] q1[$];
        logic [19:0] exp;
        apply_reset();
        do_start(12'h000, 12'h800, 12'h000, 12'h800);
        acc = '{0, 0};
        saw_full = '{0, 0};
        nxt[0] = 12'h000;
        nxt[1] = 12'h800;
        for (int c = 0; c < 40; c++) begin
            wb_valid = 2'b11;
            for (int k = 0; k < N; k++) wb_data[k] = 8'($urandom_range(1, 255));
            wb_finish = (c == 39) ? 2'b11 : 2'b00;
            @(negedge clk);
            #1;
            wcnt = '{0, 0};
            foreach (fm_log[i]) wcnt[fm_log[i][19]]++;
            for (int k = 0; k < N; k++) begin
                occ = acc[k] - wcnt[k];
                exp_rdy = (occ < DEPTH);
                if (!exp_rdy) saw_full[k] = 1'b1;
                checks++;
                if (fm_buf_ready[k] !== exp_rdy) begin
                    errors++;
                    $display("FAIL b2b_ready row%0d cyc%0d: got %b required %b (occupancy %0d)",
                             k, c, fm_buf_ready[k], exp_rdy, occ);
                end
                if (fm_buf_ready[k]) begin
                    if (k == 0) q0.push_back({nxt[k], wb_data[k]});
                    else        q1.push_back({nxt[k], wb_data[k]});
                    nxt[k] = nxt[k] + 1'b1;
                    acc[k]++;
                end
            end
            cycle();
        end
        wb_valid  = '0;
        wb_finish = '0;
        wait_done(100, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_done: got no done within 100 cycles required pulse");
        end
        checks++;
        if (!saw_full[0] || !saw_full[1]) begin
            errors++;
            $display("FAIL b2b_saturate: got full seen %b%b required 11", saw_full[1], saw_full[0]);
        end
        checks++;
        if (fm_log.size() !== acc[0] + acc[1]) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes required %0d", fm_log.size(), acc[0] + acc[1]);
        end
        for (int i = 0; i < 30 && i < fm_log.size(); i++) begin
            checks++;
            if (fm_log[i][19] !== 1'(i % 2)) begin
                errors++;
                $display("FAIL b2b_rr write%0d: got row%0d required row%0d", i, fm_log[i][19], i % 2);
            end
        end
        foreach (fm_log[i]) begin
            r = fm_log[i][19];
            if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL b2b_extra write%0d: got %h required none", i, fm_log[i]);
            end else begin
                exp = (r == 0) ? q0.pop_front() : q1.pop_front();
                checks++;
                if (fm_log[i] !== exp) begin
                    errors++;
                    $display("FAIL b2b_data write%0d: got %h required %h", i, fm_log[i], exp);
                end
            end
        end
    endtask

    task automatic test_addr_wrap();
        bit got;
        apply_reset();
        do_start(12'hFFF, 12'h100, 12'h000, 12'hFFF);
        wb_data[0]     = 8'h11;
        wb_valid[0]    = 1'b1;
        guard_i[1]     = 6'h01;
        guard_valid[1] = 1'b1;
        cycle();
        wb_data[0]     = 8'h22;
        wb_finish[0]   = 1'b1;
        guard_valid[1] = 1'b0;
        cycle();
        wb_valid       = '0;
        wb_finish      = 2'b10;
        guard_i[1]     = 6'h02;
        guard_valid[1] = 1'b1;
        cycle();
        wb_finish   = '0;
        guard_valid = '0;
        wait_done(30, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wrap_done: got no done within 30 cycles required pulse");
        end
        checks++;
        if (fm_log.size() !== 2 || fm_log[0] !== {12'hFFF, 8'h11} || fm_log[1] !== {12'h000, 8'h22}) begin
            errors++;
            $display("FAIL wrap_fm: got %0d writes first %h required fff11,00022",
                     fm_log.size(), (fm_log.size() > 0) ? fm_log[0] : 20'h0);
        end
        checks++;
        if (gd_log.size() !== 2 || gd_log[0] !== {12'hFFF, 6'h01} || gd_log[1] !== {12'h000, 6'h02}) begin
            errors++;
            $display("FAIL wrap_guard: got %0d writes first %h required %h,%h",
                     gd_log.size(), (gd_log.size() > 0) ? gd_log[0] : 18'h0,
                     {12'hFFF, 6'h01}, {12'h000, 6'h02});
        end
    endtask

    task automatic test_zero_skip();
        logic [7:0]  bytes[3];
        logic [19:0] exp_q[$];
        logic [AW-1:0] a;
        bit got;
        bytes = '{8'h55, 8'h00, 8'h66};
        a = 12'h040;
        foreach (bytes[i]) begin
            if (!(SKIP && bytes[i] == 8'h00)) exp_q.push_back({a, bytes[i]});
            a = a + 1'b1;
        end
        apply_reset();
        do_start(12'h040, 12'h100, 12'h000, 12'h100);
        wb_finish[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_data[0]   = bytes[i];
            wb_valid[0]  = 1'b1;
            wb_finish[0] = (i == 2);
            cycle();
            wb_finish[1] = 1'b0;
        end
        wb_valid  = '0;
        wb_finish = '0;
        wait_done(30, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL zero_done: got no done within 30 cycles required pulse");
        end
        checks++;
        if (fm_log.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL zero_count: got %0d writes required %0d", fm_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (fm_log[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL zero_write%0d: got %h required %h", i, fm_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int snap;
        bit bad;
        bit got;
        apply_reset();
        do_start(12'h000, 12'h800, 12'h000, 12'h800);
        // 5 beats in, 2 granted out -> 3 entries held when reset hits.
        for (int i = 0; i < 3; i++) begin
            wb_valid = (i < 2) ? 2'b11 : 2'b01;
            for (int k = 0; k < N; k++) wb_data[k] = 8'($urandom_range(1, 255));
            guard_valid = 2'b01;
            guard_i[0]  = 6'($urandom_range(0, 63));
            cycle();
        end
        wb_valid    = '0;
        guard_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        snap = fm_log.size();
        checks++;
        if ({fm_we_o, guard_we_o, done_o} !== 3'b000 || {fm_addr_o, fm_wdata_o} !== '0 ||
            {guard_addr_o, guard_wdata_o} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got we %b/%b done %b fm %h/%h required all 0",
                     fm_we_o, guard_we_o, done_o, fm_addr_o, fm_wdata_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wb_valid = 2'b11;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fm_we_o || guard_we_o || fm_buf_ready !== 2'b00) bad = 1'b1;
            cycle();
        end
        wb_valid = '0;
        checks++;
        if (bad || fm_log.size() !== snap) begin
            errors++;
            $display("FAIL midreset_quiet: got extra writes %0d or ready in idle required none",
                     fm_log.size() - snap);
        end
        do_start(12'h000, 12'h300, 12'h000, 12'h800);
        wb_data[1]  = 8'h77;
        wb_valid[1] = 1'b1;
        wb_finish   = 2'b11;
        cycle();
        wb_valid  = '0;
        wb_finish = '0;
        wait_done(30, got);
        checks++;
        if (!got || fm_log.size() !== snap + 1 || fm_log[fm_log.size() - 1] !== {12'h300, 8'h77}) begin
            errors++;
            $display("FAIL midreset_restart: got done=%b writes=%0d required done=1 single write 30077",
                     got, fm_log.size() - snap);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_addr_wrap();
        test_zero_skip();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
